// File: rtl/serdes_param_if.sv
// serdes_param_if: bus between the serdes_param channels and their user.
// slave is the serdes side, master is the controller/driver side.
`default_nettype none

interface serdes_param_if #(
    parameter int WIDTH = 8
);
    logic             des_start;
    logic             des_msb_first;
    logic             serial_in;
    logic [WIDTH-1:0] par_out;
    logic             des_valid;
    logic             des_busy;
    logic             des_perr;

    logic             ser_start;
    logic             ser_msb_first;
    logic [WIDTH-1:0] par_in;
    logic             serial_out;
    logic             ser_busy;
    logic             ser_done;

    modport slave (
        input  des_start, des_msb_first, serial_in,
        output par_out, des_valid, des_busy, des_perr,
        input  ser_start, ser_msb_first, par_in,
        output serial_out, ser_busy, ser_done
    );

    modport master (
        output des_start, des_msb_first, serial_in,
        input  par_out, des_valid, des_busy, des_perr,
        output ser_start, ser_msb_first, par_in,
        input  serial_out, ser_busy, ser_done
    );
endinterface

`default_nettype wire

// File: rtl/serdes_param.sv
// serdes_param: independent WIDTH-bit deserialiser and serialiser, selectable bit order, abort-by-restart.
// Optional even-parity bit appended to each frame when SERDES_PARITY_EN is defined.
`default_nettype none

module serdes_param #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    serdes_param_if.slave  bus
);

`ifdef SERDES_PARITY_EN
    localparam int F = WIDTH + 1;
`else
    localparam int F = WIDTH;
`endif
    localparam int            CW         = $clog2(F + 1);
    localparam logic [CW-1:0] c_F        = CW'(F);
    localparam logic [CW-1:0] c_F_LAST   = CW'(F - 1);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    state_t           des_state_q, des_state_d;
    logic [CW-1:0]    des_cnt_q,   des_cnt_d;
    logic [WIDTH-1:0] des_sr_q,    des_sr_d;
    logic [WIDTH-1:0] des_par_q,   des_par_d;
    logic             des_ord_q,   des_ord_d;
    logic             des_valid_q, des_valid_d;

    logic             w_des_last;
    logic [WIDTH-1:0] w_des_shift_start;
    logic [WIDTH-1:0] w_des_shift_run;
    logic [WIDTH-1:0] w_des_word;

    assign w_des_last = (des_state_q == S_SHIFT) && (des_cnt_q == c_F_LAST);

    // MSB-first shifts left so the first bit ends up in the top position.
    assign w_des_shift_start = bus.des_msb_first ? {{(WIDTH-1){1'b0}}, bus.serial_in}
                                                 : {bus.serial_in, {(WIDTH-1){1'b0}}};
    assign w_des_shift_run   = des_ord_q ? {des_sr_q[WIDTH-2:0], bus.serial_in}
                                         : {bus.serial_in, des_sr_q[WIDTH-1:1]};

    always_comb begin
        des_state_d = des_state_q;
        des_cnt_d   = des_cnt_q;
        des_sr_d    = des_sr_q;
        des_par_d   = des_par_q;
        des_ord_d   = des_ord_q;
        des_valid_d = 1'b0;

        if (w_des_last) begin
            des_par_d   = w_des_word;
            des_valid_d = 1'b1;
            des_state_d = S_IDLE;
        end

        // A start always wins: restart on abort, or chain onto a completing frame.
        if (bus.des_start) begin
            des_state_d = S_SHIFT;
            des_cnt_d   = c_ONE;
            des_ord_d   = bus.des_msb_first;
            des_sr_d    = w_des_shift_start;
        end else if ((des_state_q == S_SHIFT) && !w_des_last) begin
            des_cnt_d   = des_cnt_q + c_ONE;
            des_sr_d    = w_des_shift_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            des_state_q <= S_IDLE;
            des_cnt_q   <= '0;
            des_sr_q    <= '0;
            des_par_q   <= '0;
            des_ord_q   <= 1'b0;
            des_valid_q <= 1'b0;
        end else begin
            des_state_q <= des_state_d;
            des_cnt_q   <= des_cnt_d;
            des_sr_q    <= des_sr_d;
            des_par_q   <= des_par_d;
            des_ord_q   <= des_ord_d;
            des_valid_q <= des_valid_d;
        end
    end

    assign bus.par_out   = des_par_q;
    assign bus.des_valid = des_valid_q;
    assign bus.des_busy  = (des_state_q == S_SHIFT);

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_t           ser_state_q, ser_state_d;
    logic [CW-1:0]    ser_cnt_q,   ser_cnt_d;
    logic [WIDTH-1:0] ser_sr_q,    ser_sr_d;
    logic             ser_ord_q,   ser_ord_d;
    logic             ser_out_q,   ser_out_d;
    logic             ser_done_q,  ser_done_d;

    logic             w_ser_last;
    logic             w_ser_first;
    logic             w_ser_data_bit;
    logic             w_ser_next_bit;

    // ser_cnt_q counts bits driven so far, including the one on the line now.
    assign w_ser_last     = (ser_state_q == S_SHIFT) && (ser_cnt_q == c_F);
    assign w_ser_first    = bus.ser_msb_first ? bus.par_in[WIDTH-1] : bus.par_in[0];
    assign w_ser_data_bit = ser_ord_q ? ser_sr_q[WIDTH-1] : ser_sr_q[0];

    always_comb begin
        ser_state_d = ser_state_q;
        ser_cnt_d   = ser_cnt_q;
        ser_sr_d    = ser_sr_q;
        ser_ord_d   = ser_ord_q;
        ser_out_d   = ser_out_q;
        ser_done_d  = 1'b0;

        if (w_ser_last) begin
            ser_state_d = S_IDLE;
            ser_out_d   = IDLE_LEVEL;
            ser_done_d  = 1'b1;
        end

        if (bus.ser_start) begin
            ser_state_d = S_SHIFT;
            ser_cnt_d   = c_ONE;
            ser_ord_d   = bus.ser_msb_first;
            ser_out_d   = w_ser_first;
            ser_sr_d    = bus.ser_msb_first ? (bus.par_in << 1) : (bus.par_in >> 1);
        end else if ((ser_state_q == S_SHIFT) && !w_ser_last) begin
            ser_cnt_d   = ser_cnt_q + c_ONE;
            ser_out_d   = w_ser_next_bit;
            ser_sr_d    = ser_ord_q ? (ser_sr_q << 1) : (ser_sr_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_state_q <= S_IDLE;
            ser_cnt_q   <= '0;
            ser_sr_q    <= '0;
            ser_ord_q   <= 1'b0;
            ser_out_q   <= IDLE_LEVEL;
            ser_done_q  <= 1'b0;
        end else begin
            ser_state_q <= ser_state_d;
            ser_cnt_q   <= ser_cnt_d;
            ser_sr_q    <= ser_sr_d;
            ser_ord_q   <= ser_ord_d;
            ser_out_q   <= ser_out_d;
            ser_done_q  <= ser_done_d;
        end
    end

    assign bus.serial_out = ser_out_q;
    assign bus.ser_busy   = (ser_state_q == S_SHIFT);
    assign bus.ser_done   = ser_done_q;

    // ------------------------------------------------------------------
    // Parity (trailing bit, independent of bit order)
    // ------------------------------------------------------------------
`ifdef SERDES_PARITY_EN
    logic des_acc_q;
    logic des_perr_q;
    logic ser_par_q;

    // Data is complete before the parity bit arrives, so the word is the shift register.
    assign w_des_word     = des_sr_q;
    assign w_ser_next_bit = (ser_cnt_q == CW'(WIDTH)) ? ser_par_q : w_ser_data_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            des_acc_q  <= 1'b0;
            des_perr_q <= 1'b0;
            ser_par_q  <= 1'b0;
        end else begin
            if (w_des_last) begin
                des_perr_q <= des_acc_q ^ bus.serial_in;
            end
            if (bus.des_start) begin
                des_acc_q <= bus.serial_in;
            end else if (des_state_q == S_SHIFT) begin
                des_acc_q <= des_acc_q ^ bus.serial_in;
            end
            if (bus.ser_start) begin
                ser_par_q <= ^bus.par_in;
            end
        end
    end

    assign bus.des_perr = des_perr_q;
`else
    assign w_des_word     = w_des_shift_run;
    assign w_ser_next_bit = w_ser_data_bit;
    assign bus.des_perr   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serdes_param.sv
// tb_serdes_param: table-driven and scoreboard checks of serdes_param (WIDTH=8, IDLE_LEVEL=1).
`default_nettype none

module tb_serdes_param;
    localparam int W = 8;
`ifdef SERDES_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serdes_param_if #(.WIDTH(W)) bus ();

    logic tb_sin;
    logic loop_en;
    always_comb bus.serial_in = loop_en ? bus.serial_out : tb_sin;

    serdes_param #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] sb_q[$];
    logic         sb_en;

    typedef struct {
        logic       is_des;
        logic       msb;
        logic [7:0] val;
        logic [7:0] seq;   // line bits in time order, seq[7] first
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_en && bus.des_valid) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL loopback_unexpected: actual=valid required=no valid, word=%0h", bus.par_out);
            end else begin
                logic [W-1:0] e;
                e = sb_q.pop_front();
                chk("loopback_word", bus.par_out, e);
                chk("loopback_perr", bus.des_perr, 0);
            end
        end
    end

    task automatic run_ser(input logic msb, input logic [7:0] val, input logic [7:0] seq);
        logic b;
        bus.ser_start = 1'b1; bus.ser_msb_first = msb; bus.par_in = val;
        tick();
        bus.ser_start = 1'b0; bus.ser_msb_first = ~msb; bus.par_in = ~val;
        for (int i = 0; i < F; i++) begin
            b = (i < 8) ? seq[7-i] : ^val;
            chk("ser_bit", bus.serial_out, b);
            chk("ser_busy", bus.ser_busy, 1);
            chk("ser_done_early", bus.ser_done, 0);
            tick();
        end
        chk("ser_idle_level", bus.serial_out, 1);
        chk("ser_done", bus.ser_done, 1);
        chk("ser_busy_end", bus.ser_busy, 0);
        tick();
        chk("ser_done_one_cycle", bus.ser_done, 0);
    endtask

    task automatic run_des(input logic msb, input logic [7:0] val, input logic [7:0] seq);
        bus.des_start = 1'b1; bus.des_msb_first = msb; tb_sin = seq[7];
        tick();
        bus.des_start = 1'b0; bus.des_msb_first = ~msb;
        chk("des_busy", bus.des_busy, 1);
        for (int i = 1; i < F; i++) begin
            tb_sin = (i < 8) ? seq[7-i] : ^val;
            chk("des_valid_early", bus.des_valid, 0);
            tick();
        end
        chk("des_valid", bus.des_valid, 1);
        chk("des_word", bus.par_out, val);
        chk("des_busy_end", bus.des_busy, 0);
        chk("des_perr", bus.des_perr, 0);
        tick();
        chk("des_valid_one_cycle", bus.des_valid, 0);
        chk("des_word_hold", bus.par_out, val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seqn;
        logic [W-1:0] w;
        logic m;
        int t;

        tbl[0] = '{1'b0, 1'b1, 8'hA5, 8'b10100101};
        tbl[1] = '{1'b0, 1'b0, 8'h6E, 8'b01110110};
        tbl[2] = '{1'b0, 1'b0, 8'h01, 8'b10000000};
        tbl[3] = '{1'b0, 1'b1, 8'h01, 8'b00000001};
        tbl[4] = '{1'b1, 1'b0, 8'h53, 8'b11001010};
        tbl[5] = '{1'b1, 1'b1, 8'hCA, 8'b11001010};
        tbl[6] = '{1'b1, 1'b0, 8'h80, 8'b00000001};
        tbl[7] = '{1'b1, 1'b1, 8'h01, 8'b00000001};

        rst_n = 1'b0; loop_en = 1'b0; sb_en = 1'b0; tb_sin = 1'b0;
        bus.des_start = 1'b0; bus.des_msb_first = 1'b0;
        bus.ser_start = 1'b0; bus.ser_msb_first = 1'b0; bus.par_in = '0;
        tick(); tick();
        chk("rst_par_out", bus.par_out, 0);
        chk("rst_des_valid", bus.des_valid, 0);
        chk("rst_des_busy", bus.des_busy, 0);
        chk("rst_des_perr", bus.des_perr, 0);
        chk("rst_serial_out", bus.serial_out, 1);
        chk("rst_ser_busy", bus.ser_busy, 0);
        chk("rst_ser_done", bus.ser_done, 0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) begin
            if (tbl[k].is_des) run_des(tbl[k].msb, tbl[k].val, tbl[k].seq);
            else               run_ser(tbl[k].msb, tbl[k].val, tbl[k].seq);
        end

        // Serialiser abort after 3 bits of 8'hFF, replaced by 8'h00.
        bus.ser_start = 1'b1; bus.par_in = 8'hFF; bus.ser_msb_first = 1'b1;
        tick();
        bus.ser_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_old_bit", bus.serial_out, 1);
            chk("abort_no_done", bus.ser_done, 0);
            if (i < 2) tick();
        end
        bus.ser_start = 1'b1; bus.par_in = 8'h00;
        tick();
        bus.ser_start = 1'b0;
        for (int i = 0; i < F; i++) begin
            chk("abort_new_bit", bus.serial_out, 0);
            chk("abort_no_done_new", bus.ser_done, 0);
            tick();
        end
        chk("abort_done", bus.ser_done, 1);
        chk("abort_idle", bus.serial_out, 1);
        tick();

        // Serialiser restart in the done cycle.
        bus.ser_start = 1'b1; bus.par_in = 8'h81; bus.ser_msb_first = 1'b0;
        tick();
        bus.ser_start = 1'b0;
        for (int i = 0; i < F - 1; i++) tick();
        bus.ser_start = 1'b1; bus.par_in = 8'h02; bus.ser_msb_first = 1'b0;
        tick();
        bus.ser_start = 1'b0;
        chk("chain_done", bus.ser_done, 1);
        chk("chain_first_bit", bus.serial_out, 0);
        chk("chain_busy", bus.ser_busy, 1);
        tick();
        chk("chain_done_one_cycle", bus.ser_done, 0);
        chk("chain_second_bit", bus.serial_out, 1);
        for (int i = 0; i < F - 1; i++) tick();
        chk("chain_final_done", bus.ser_done, 1);
        tick();

        // Deserialiser abort after 3 bits, then a full frame.
        bus.des_start = 1'b1; bus.des_msb_first = 1'b0; tb_sin = 1'b1;
        tick();
        bus.des_start = 1'b0;
        tick(); tick();
        run_des(1'b0, 8'h53, 8'b11001010);

        // des_start coinciding with the last sample: completion plus new frame.
        seqn = 8'b11001010;
        bus.des_start = 1'b1; bus.des_msb_first = 1'b0; tb_sin = seqn[7];
        tick();
        bus.des_start = 1'b0;
        for (int i = 1; i < F - 1; i++) begin
            tb_sin = seqn[7-i];
            tick();
        end
        tb_sin = 1'b0;   // last data bit (or parity of 8'h53) is 0
        bus.des_start = 1'b1; bus.des_msb_first = 1'b1;
        tick();
        bus.des_start = 1'b0;
        chk("dchain_valid", bus.des_valid, 1);
        chk("dchain_word", bus.par_out, 8'h53);
        chk("dchain_busy", bus.des_busy, 1);
        seqn = 8'b01101001;
        for (int i = 1; i < F; i++) begin
            tb_sin = (i < 8) ? seqn[7-i] : ^seqn;
            tick();
            if (i < F - 1) chk("dchain_no_valid", bus.des_valid, 0);
        end
        chk("dchain_valid2", bus.des_valid, 1);
        chk("dchain_word2", bus.par_out, 8'h69);
        tick();

        // Asynchronous reset in the middle of both frames.
        bus.des_start = 1'b1; bus.des_msb_first = 1'b0; tb_sin = 1'b1;
        bus.ser_start = 1'b1; bus.par_in = 8'h00; bus.ser_msb_first = 1'b1;
        tick();
        bus.des_start = 1'b0; bus.ser_start = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_serial_out", bus.serial_out, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_par_out", bus.par_out, 0);
        chk("arst_des_valid", bus.des_valid, 0);
        chk("arst_des_busy", bus.des_busy, 0);
        chk("arst_serial_out", bus.serial_out, 1);
        chk("arst_ser_busy", bus.ser_busy, 0);
        chk("arst_ser_done", bus.ser_done, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * F; i++) begin
            tb_sin = i[0];
            tick();
            chk("post_rst_no_valid", bus.des_valid, 0);
            chk("post_rst_no_done", bus.ser_done, 0);
        end
        run_des(1'b1, 8'hCA, 8'b11001010);

`ifdef SERDES_PARITY_EN
        run_ser(1'b0, 8'h07, 8'b11100000);
        seqn = 8'b11100000;
        bus.des_start = 1'b1; bus.des_msb_first = 1'b0; tb_sin = seqn[7];
        tick();
        bus.des_start = 1'b0;
        for (int i = 1; i < F; i++) begin
            tb_sin = (i < 8) ? seqn[7-i] : 1'b0;   // flipped parity
            tick();
        end
        chk("perr_valid", bus.des_valid, 1);
        chk("perr_word", bus.par_out, 8'h07);
        chk("perr_flag", bus.des_perr, 1);
        tick();
        run_des(1'b0, 8'h07, 8'b11100000);
`endif

        // Loopback with scoreboard.
        loop_en = 1'b1; sb_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            w = W'($urandom);
            m = 1'($urandom_range(0, 1));
            bus.ser_start = 1'b1; bus.par_in = w; bus.ser_msb_first = m;
            sb_q.push_back(w);
            tick();
            bus.ser_start = 1'b0;
            bus.des_start = 1'b1; bus.des_msb_first = m;
            tick();
            bus.des_start = 1'b0;
            t = 0;
            while (sb_q.size() != 0 && t < 3 * F) begin
                tick();
                t++;
            end
            if (sb_q.size() != 0) begin
                n_chk++;
                n_err++;
                $display("FAIL loopback_timeout: actual=no des_valid required=des_valid for word %0h", w);
                sb_q.delete();
            end
            tick();
        end
        loop_en = 1'b0; sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/serdes_param.md
Name: serdes_param

Overview:
- Parametrised successor to the team's 8-bit serialiser/deserialiser.
- Provides one independent deserialiser (serial -> WIDTH-bit word) and one independent serialiser (WIDTH-bit word -> serial) on a shared clock.
- Adds per-transfer bit-order selection, busy flags, a one-cycle valid/done pulse, a programmable idle line level and abort-by-restart.
- Sits between the memory controller's command/data path and bit-serial memory pins.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..64.
- IDLE_LEVEL, 1'b1: value driven on serial_out when the serialiser is idle.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- des_start  in  1  start a deserialise frame; serial_in is sampled in this cycle.
- des_msb_first  in  1  bit order for the frame; sampled only when des_start is high.
- serial_in  in  1  serial data input.
- par_out  out  WIDTH  last completed deserialised word; held until the next completion.
- des_valid  out  1  one-cycle pulse when par_out updates.
- des_busy  out  1  high while a deserialise frame is in progress.
- des_perr  out  1  parity error flag; valid with des_valid.
- ser_start  in  1  load par_in and begin serialising.
- ser_msb_first  in  1  bit order; sampled only when ser_start is high.
- par_in  in  WIDTH  word to serialise; sampled only when ser_start is high.
- serial_out  out  1  registered serial data output.
- ser_busy  out  1  high while frame bits are being driven.
- ser_done  out  1  one-cycle pulse in the cycle after the last bit has been driven.

Behaviour:
- Reset (async, rst_n=0):
  - par_out=0, des_valid=0, des_busy=0, des_perr=0.
  - serial_out=IDLE_LEVEL, ser_busy=0, ser_done=0.
  - Internal counters and shift registers are 0; both FSMs go to IDLE.
  - Reset during a frame discards it, with no valid or done pulse.
- Frame length: F=WIDTH, or WIDTH+1 with parity enabled. Counters are $clog2(F+1) bits wide.
- Deserialiser FSM, states IDLE and SHIFT:
  - IDLE: on des_start, sample bit 0, set cnt=1, latch the order, go to SHIFT; des_busy=1 from the next cycle.
  - SHIFT: sample one bit per cycle.
  - When the F-th bit is sampled, at that edge: par_out <= word, des_valid <= 1 for exactly one cycle, des_busy <= 0, return to IDLE.
  - Latency: des_valid is high in the cycle after the last sample; F cycles from the des_start cycle.
  - des_msb_first=1: the first bit received lands in par_out[WIDTH-1]. Otherwise it lands in par_out[0].
  - des_start while in SHIFT aborts the current frame (no pulse) and restarts it, treating this cycle's bit as bit 0.
  - des_start in the same cycle as the last sample: the completion pulse for the current frame fires and a new frame starts with this bit as bit 0. Abort does not apply at this cycle.
- Serialiser FSM, states IDLE and SHIFT:
  - IDLE: on ser_start, latch par_in and the order. serial_out <= first bit at that edge, ser_busy <= 1, go to SHIFT.
  - SHIFT: each bit is held on serial_out for exactly one cycle. After the F-th bit's cycle: serial_out <= IDLE_LEVEL, ser_busy <= 0, ser_done <= 1 for one cycle.
  - ser_msb_first=1 drives par_in[WIDTH-1] first; otherwise par_in[0] first.
  - ser_start while in SHIFT aborts (no ser_done) and the new word's first bit appears at the next edge.
  - ser_start in the cycle ser_done would be generated: ser_done still pulses, and the new frame's first bit is driven from that edge.
- The two channels are fully independent; simultaneous starts are legal.

Optional Feature:
- Macro: SERDES_PARITY_EN.
- Defined:
  - Serialiser appends one even-parity bit (XOR of the WIDTH data bits) after the data, so F=WIDTH+1.
  - Deserialiser samples WIDTH+1 bits and sets des_perr=1 with des_valid when the XOR of all WIDTH+1 bits is 1. des_perr is cleared at the next des_valid.
  - Parity is always the last bit, regardless of bit order.
- Not defined:
  - F=WIDTH.
  - des_perr is tied to 0.
  - No parity logic is synthesised.

Test Plan (WIDTH=8, IDLE_LEVEL=1, no parity unless stated):
- Serialiser MSB-first: par_in=8'hA5, ser_start for 1 cycle -> serial_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_busy high those 8 cycles; then serial_out=1 and ser_done pulses for 1 cycle.
- Deserialiser LSB-first: drive 1,1,0,0,1,0,1,0 starting in the des_start cycle -> des_valid pulses 8 cycles after start, par_out=8'h53, des_busy low afterwards.
- Loopback: serial_out feeds serial_in, des_start asserted 1 cycle after ser_start, random words in both orders -> par_out equals par_in for 100 words.
- Abort: ser_start with 8'hFF, ser_start with 8'h00 after 3 bits -> no ser_done for the first word; eight 0s follow, then ser_done.
- Reset mid-frame: rst_n low for 1 cycle after 4 bits of deserialise -> all outputs at reset values immediately (async); no des_valid until a new full frame completes.
- With SERDES_PARITY_EN defined: send 8'h07 (parity bit 1) -> 9 bits driven; loopback des_perr=0. Flip the parity bit on the line -> des_perr=1 with des_valid.
